// File: rtl/baud_pulse_generator.sv
// Baud tick generator: one-clock strobe every DIV clocks while en is high, first strobe DIV clocks after enable.
// No backpressure; dropping en or rst_n clears the phase so the next enable starts a fresh bit period.
`timescale 1ns/1ps
module baud_pulse_generator #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic baud_pulse
);

  // Clock-to-baud ratio rounded to nearest, halves rounded up.
  localparam int DIV = (BAUD_RATE > 0) ? (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE : 0;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (BAUD_RATE <= 0) begin : g_bad_baud
    $error("baud_pulse_generator: BAUD_RATE must be greater than 0");
  end
  if (DIV < 2) begin : g_bad_div
    $error("baud_pulse_generator: CLK_FREQ/BAUD_RATE must round to at least 2");
  end

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      baud_pulse <= 1'b0;
    end else if (!en) begin
      cnt        <= '0;
      baud_pulse <= 1'b0;
    end else if (cnt == LAST) begin
      cnt        <= '0;
      baud_pulse <= 1'b1;
    end else begin
      cnt        <= cnt + CW'(1);
      baud_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_baud_pulse_generator.sv
// Directed bench for baud_pulse_generator: default 25 MHz / 115200 instance plus three rounding instances.
`timescale 1ns/1ps
module tb_baud_pulse_generator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic en_s = 1'b0;
  logic baud_pulse;
  logic bp_a, bp_b, bp_c;

  int checks = 0;
  int errors = 0;

  always #20 clk = ~clk;

  baud_pulse_generator dut (
    .clk(clk), .rst_n(rst_n), .en(en), .baud_pulse(baud_pulse)
  );

  baud_pulse_generator #(.CLK_FREQ(100), .BAUD_RATE(30)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_s), .baud_pulse(bp_a)
  );

  baud_pulse_generator #(.CLK_FREQ(100), .BAUD_RATE(40)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_s), .baud_pulse(bp_b)
  );

  baud_pulse_generator #(.CLK_FREQ(8), .BAUD_RATE(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en_s), .baud_pulse(bp_c)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clocks, sampling 1 ns after each edge. Edge k counts from 1.
  // bad counts pulses wider than one clock or not 217 clocks after the previous one.
  task automatic run(input int n, output int np, output int first, output int bad);
    int   last;
    logic prev;
    np = 0; first = -1; bad = 0; last = 0; prev = baud_pulse;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (baud_pulse) begin
        if (prev) bad++;
        else begin
          if (np == 0) first = k;
          else if (k - last != 217) bad++;
          last = k;
          np++;
        end
      end
      prev = baud_pulse;
    end
  endtask

  task automatic sample_small(output logic [11:0] a, output logic [11:0] b, output logic [11:0] c);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      a[k] = bp_a;
      b[k] = bp_b;
      c[k] = bp_c;
    end
  endtask

  initial begin
    int np, first, bad;
    logic [11:0] pa, pb, pc;

    // Reset overrides en.
    rst_n = 1'b0; en = 1'b1;
    run(3, np, first, bad);
    check("reset_pulse_low", int'(baud_pulse), 0);
    check("reset_no_pulse", np, 0);
    check("reset_small_low", int'({bp_a, bp_b, bp_c}), 0);

    // 1 ms run at 40 ns: 25000 clocks.
    rst_n = 1'b1; en = 1'b1;
    run(25000, np, first, bad);
    check("1ms_pulse_count", np, 115);
    check("1ms_first_pulse", first, 217);
    check("1ms_spacing_width", bad, 0);

    // en held low for 1000 clocks.
    en = 1'b0;
    run(1000, np, first, bad);
    check("en_low_no_pulse", np, 0);
    check("en_low_level", int'(baud_pulse), 0);

    // Disable mid-count then re-enable.
    en = 1'b1;
    run(150, np, first, bad);
    check("mid_first_window", np, 0);
    en = 1'b0;
    run(10, np, first, bad);
    check("mid_disabled", np, 0);
    en = 1'b1;
    run(217, np, first, bad);
    check("mid_reenable_first", first, 217);
    check("mid_reenable_count", np, 1);
    run(1, np, first, bad);
    check("mid_one_clock_wide", int'(baud_pulse), 0);

    // Drop en on the exact wrap edge: pulse cancelled.
    en = 1'b0;
    run(5, np, first, bad);
    en = 1'b1;
    run(216, np, first, bad);
    check("wrap_pre_count", np, 0);
    en = 1'b0;
    run(1, np, first, bad);
    check("wrap_suppressed", int'(baud_pulse), 0);
    en = 1'b1;
    run(217, np, first, bad);
    check("wrap_restart_first", first, 217);
    check("wrap_restart_count", np, 1);

    // Reset mid-operation at clock 300 with en high.
    en = 1'b0;
    run(2, np, first, bad);
    en = 1'b1;
    run(300, np, first, bad);
    check("rst_pre_count", np, 1);
    rst_n = 1'b0;
    run(1, np, first, bad);
    check("rst_mid_pulse_low", int'(baud_pulse), 0);
    rst_n = 1'b1;
    run(217, np, first, bad);
    check("rst_restart_first", first, 217);
    check("rst_restart_count", np, 1);

    // Reset on the exact wrap edge also cancels the pulse.
    run(216, np, first, bad);
    check("rst_wrap_pre", np, 0);
    rst_n = 1'b0;
    run(1, np, first, bad);
    check("rst_wrap_suppressed", int'(baud_pulse), 0);
    rst_n = 1'b1;

    // Rounding instances: bit k is the strobe after the (k+1)th enabled edge.
    en_s = 1'b1;
    sample_small(pa, pb, pc);
    check("div_100_30", int'(pa), 'h924);
    check("div_100_40", int'(pb), 'h924);
    check("div_8_4", int'(pc), 'hAAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
